// File: rtl/dcache_pkg.sv
// Shared types, widths and address-field helpers for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int unsigned NUM_LINES = 32;
    localparam int unsigned INDEX_W   = $clog2(NUM_LINES);
    localparam int unsigned LINE_W    = 256;
    localparam int unsigned OFFSET_W  = $clog2(LINE_W / 8);
    localparam int unsigned TAG_W     = 32 - INDEX_W - OFFSET_W;
    localparam int unsigned WORD_W    = OFFSET_W - 2;

    typedef enum logic [1:0] {IDLE, WB, ALLOC, FILL} state_e;

    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [INDEX_W-1:0] index_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [LINE_W-1:0]  line_t;

    // Registered memory-side request bundle
    typedef struct packed {
        logic        enable;
        logic        write;
        logic [31:0] addr;
        line_t       data;
    } mem_req_t;

    function automatic tag_t addr_tag(input logic [31:0] addr);
        return addr[31 -: TAG_W];
    endfunction

    function automatic index_t addr_index(input logic [31:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic word_t addr_word(input logic [31:0] addr);
        return addr[2 +: WORD_W];
    endfunction

    function automatic logic [31:0] line_addr(input tag_t tag, input index_t index);
        return {tag, index, OFFSET_W'(0)};
    endfunction

endpackage

// File: rtl/dcache_mem_initiator_if.sv
// CPU-side and line-memory-side signal bundle of the data cache controller.
interface dcache_mem_initiator_if;

    logic                          cpu_req_i;
    logic                          cpu_we_i;
    logic [31:0]                   cpu_addr_i;
    logic [31:0]                   cpu_wdata_i;
    logic [31:0]                   cpu_rdata_o;
    logic                          cpu_stall_o;
    logic                          mem_enable_o;
    logic                          mem_write_o;
    logic [31:0]                   mem_addr_o;
    logic [dcache_pkg::LINE_W-1:0] mem_data_o;
    logic [dcache_pkg::LINE_W-1:0] mem_data_i;
    logic                          mem_ack_i;
    logic [31:0]                   hit_cnt_o;
    logic [31:0]                   miss_cnt_o;

    modport master (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_data_i, mem_ack_i,
        output cpu_rdata_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o,
               mem_data_o, hit_cnt_o, miss_cnt_o
    );

    modport slave (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_data_i, mem_ack_i,
        input  cpu_rdata_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o,
               mem_data_o, hit_cnt_o, miss_cnt_o
    );

endinterface

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage: async read by index, sync full-line fill or 32-bit word store.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  index_t rd_index,
    output logic   rd_valid_c,
    output logic   rd_dirty_c,
    output tag_t   rd_tag_c,
    output line_t  rd_line_c,
    input  logic   fill_we,
    input  index_t fill_index,
    input  tag_t   fill_tag,
    input  line_t  fill_line,
    input  logic   store_we,
    input  index_t store_index,
    input  word_t  store_word,
    input  logic [31:0] store_data
);

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    tag_t                 tag_mem  [NUM_LINES];
    line_t                data_mem [NUM_LINES];

    assign rd_valid_c = valid[rd_index];
    assign rd_dirty_c = dirty[rd_index];
    assign rd_tag_c   = tag_mem[rd_index];
    assign rd_line_c  = data_mem[rd_index];

    // Only the status bits are reset; stale tags are masked by valid=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (fill_we) begin
                valid[fill_index] <= 1'b1;
                dirty[fill_index] <= 1'b0;
            end
            if (store_we) begin
                dirty[store_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= fill_line;
        end else if (store_we) begin
            data_mem[store_index][{store_word, 5'b00000} +: 32] <= store_data;
        end
    end

endmodule

// File: rtl/dcache_mem_initiator.sv
// Direct-mapped write-back/write-allocate D-cache controller, initiator of the 256-bit line protocol.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_mem_initiator
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    dcache_mem_initiator_if.master bus
);

    state_e   state;
    state_e   state_nxt;
    mem_req_t mem_q;
    mem_req_t mem_d;
    tag_t     miss_tag;
    tag_t     miss_tag_nxt;
    index_t   miss_index;
    index_t   miss_index_nxt;

    logic     rd_valid_c;
    logic     rd_dirty_c;
    tag_t     rd_tag_c;
    line_t    rd_line_c;

    tag_t     cpu_tag;
    index_t   cpu_index;
    word_t    cpu_word;
    logic     hit_c;
    logic     serve_c;
    logic     stall_c;
    logic     store_we;
    logic     fill_we;

    assign cpu_tag   = addr_tag(bus.cpu_addr_i);
    assign cpu_index = addr_index(bus.cpu_addr_i);
    assign cpu_word  = addr_word(bus.cpu_addr_i);

    // Hits are served only from IDLE; during a miss the request keeps stalling
    assign hit_c    = rd_valid_c && (rd_tag_c == cpu_tag);
    assign serve_c  = bus.cpu_req_i && hit_c && (state == IDLE);
    assign stall_c  = bus.cpu_req_i && !serve_c;
    assign store_we = serve_c && bus.cpu_we_i;
    assign fill_we  = (state == FILL);

    dcache_line_array u_lines (
        .clk         (clk_i),
        .rst_n       (rst_i),
        .rd_index    (cpu_index),
        .rd_valid_c  (rd_valid_c),
        .rd_dirty_c  (rd_dirty_c),
        .rd_tag_c    (rd_tag_c),
        .rd_line_c   (rd_line_c),
        .fill_we     (fill_we),
        .fill_index  (miss_index),
        .fill_tag    (miss_tag),
        .fill_line   (bus.mem_data_i),
        .store_we    (store_we),
        .store_index (cpu_index),
        .store_word  (cpu_word),
        .store_data  (bus.cpu_wdata_i)
    );

    assign bus.cpu_stall_o  = stall_c;
    assign bus.cpu_rdata_o  = rd_line_c[{cpu_word, 5'b00000} +: 32];
    assign bus.mem_enable_o = mem_q.enable;
    assign bus.mem_write_o  = mem_q.write;
    assign bus.mem_addr_o   = mem_q.addr;
    assign bus.mem_data_o   = mem_q.data;

    // Next-state and next memory-request logic
    always_comb begin
        state_nxt      = state;
        mem_d          = mem_q;
        miss_tag_nxt   = miss_tag;
        miss_index_nxt = miss_index;
        case (state)
            IDLE: begin
                if (bus.cpu_req_i && !hit_c) begin
                    miss_tag_nxt   = cpu_tag;
                    miss_index_nxt = cpu_index;
                    mem_d.enable   = 1'b1;
                    if (rd_valid_c && rd_dirty_c) begin
                        state_nxt   = WB;
                        mem_d.write = 1'b1;
                        mem_d.addr  = line_addr(rd_tag_c, cpu_index);
                        mem_d.data  = rd_line_c;
                    end else begin
                        state_nxt   = ALLOC;
                        mem_d.write = 1'b0;
                        mem_d.addr  = line_addr(cpu_tag, cpu_index);
                    end
                end
            end
            WB: begin
                if (bus.mem_ack_i) begin
                    mem_d.enable = 1'b0;
                    state_nxt    = ALLOC;
                end
            end
            ALLOC: begin
                // Enable low here means the one-cycle gap after a write-back has elapsed
                if (!mem_q.enable) begin
                    mem_d.enable = 1'b1;
                    mem_d.write  = 1'b0;
                    mem_d.addr   = line_addr(miss_tag, miss_index);
                end else if (bus.mem_ack_i) begin
                    mem_d.enable = 1'b0;
                    state_nxt    = FILL;
                end
            end
            FILL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            mem_q      <= '0;
            miss_tag   <= '0;
            miss_index <= '0;
        end else begin
            state      <= state_nxt;
            mem_q      <= mem_d;
            miss_tag   <= miss_tag_nxt;
            miss_index <= miss_index_nxt;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    // Free-running wrap-around statistics
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (bus.cpu_req_i && !stall_c) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if ((state == IDLE) && (state_nxt != IDLE)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign bus.hit_cnt_o  = hit_cnt;
    assign bus.miss_cnt_o = miss_cnt;
`else
    assign bus.hit_cnt_o  = 32'd0;
    assign bus.miss_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_mem_initiator.sv
// Bench for dcache_mem_initiator: directed scenarios plus random traffic against a cache/memory model.
module tb_dcache_mem_initiator;

    typedef struct packed {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    logic clk_i;
    logic rst_i;
    dcache_mem_initiator_if bus ();

    dcache_mem_initiator dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    txn_t txn_q[$];
    txn_t exp_q[$];
    int unsigned resp_lat = 8;

    logic [255:0] env_mem [bit [31:0]];
    logic [255:0] ref_mem [bit [31:0]];

    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_line  [32];
    int unsigned  m_hits = 0;
    int unsigned  m_miss = 0;
    logic [31:0]  last_rdata;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] init_line(input bit [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = (a * 32'h9E37_79B1) ^ (32'(w) * 32'h85EB_CA77) ^ 32'hA5A5_0000;
        end
        return l;
    endfunction

    function automatic logic [255:0] env_get(input bit [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : init_line(a);
    endfunction

    function automatic logic [255:0] ref_get(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    // Reference: what a direct-mapped write-back cache must do for one access
    task automatic model_step(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input bit count_hit, output bit hit, output logic [31:0] rd);
        logic [4:0]  idx;
        logic [21:0] tag;
        int          w;
        logic [31:0] la;
        idx = addr[9:5];
        tag = addr[31:10];
        w   = int'(addr[4:2]);
        exp_q.delete();
        hit = m_valid[idx] && (m_tag[idx] == tag);
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                la = {m_tag[idx], idx, 5'b00000};
                exp_q.push_back('{wr: 1'b1, addr: la, data: m_line[idx]});
                ref_mem[la] = m_line[idx];
            end
            la = {tag, idx, 5'b00000};
            exp_q.push_back('{wr: 1'b0, addr: la, data: 256'd0});
            m_line[idx]  = ref_get(la);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
            m_miss++;
        end
        rd = m_line[idx][w*32 +: 32];
        if (we) begin
            m_line[idx][w*32 +: 32] = wdata;
            m_dirty[idx] = 1'b1;
        end
        if (count_hit) m_hits++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic check_txns();
        check("txn_count", 256'(txn_q.size()), 256'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < txn_q.size()) begin
                check("txn_write", 256'(txn_q[i].wr), 256'(exp_q[i].wr));
                check("txn_addr", 256'(txn_q[i].addr), 256'(exp_q[i].addr));
                if (exp_q[i].wr) check("txn_data", txn_q[i].data, exp_q[i].data);
            end
        end
    endtask

    task automatic check_counters();
`ifdef DCACHE_STATS_EN
        check("hit_cnt", 256'(bus.hit_cnt_o), 256'(m_hits));
        check("miss_cnt", 256'(bus.miss_cnt_o), 256'(m_miss));
`else
        check("hit_cnt", 256'(bus.hit_cnt_o), 256'(0));
        check("miss_cnt", 256'(bus.miss_cnt_o), 256'(0));
`endif
    endtask

    // One CPU access held until released; entered and left at #1 after a rising edge
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        bit          hit;
        logic [31:0] exp_rd;
        int          cyc;
        model_step(we, addr, wdata, 1'b1, hit, exp_rd);
        txn_q.delete();
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wdata;
        @(negedge clk_i);
        check("first_stall", 256'(bus.cpu_stall_o), 256'(!hit));
        cyc = 0;
        while (bus.cpu_stall_o !== 1'b0 && cyc < 300) begin
            @(negedge clk_i);
            cyc++;
        end
        check("stall_release", 256'(bus.cpu_stall_o), 256'(1'b0));
        if (!we) check("load_data", 256'(bus.cpu_rdata_o), 256'(exp_rd));
        last_rdata = bus.cpu_rdata_o;
        @(posedge clk_i);
        #1;
        bus.cpu_req_i = 1'b0;
        check_txns();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Line-memory responder with protocol checks
    initial begin : responder
        bit   busy;
        bit   post_ack;
        bit   expect_reissue;
        int   left;
        txn_t cur;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        busy = 1'b0; post_ack = 1'b0; expect_reissue = 1'b0; left = 0;
        cur = '0;
        forever begin
            @(posedge clk_i);
            #1;
            bus.mem_ack_i = 1'b0;
            if (!rst_i) begin
                busy = 1'b0; post_ack = 1'b0; expect_reissue = 1'b0;
            end else if (post_ack) begin
                post_ack = 1'b0;
                check("no_b2b_enable", 256'(bus.mem_enable_o), 256'(1'b0));
                if (!cur.wr) bus.mem_data_i = env_get(cur.addr);
                expect_reissue = cur.wr;
            end else if (busy) begin
                check("hold_req", 256'({bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o}),
                      256'({1'b1, cur.wr, cur.addr}));
                if (cur.wr) check("hold_data", bus.mem_data_o, cur.data);
                if (left == 0) begin
                    bus.mem_ack_i = 1'b1;
                    busy = 1'b0;
                    post_ack = 1'b1;
                    txn_q.push_back(cur);
                    if (cur.wr) env_mem[cur.addr] = cur.data;
                end else begin
                    left--;
                end
            end else begin
                if (expect_reissue) begin
                    expect_reissue = 1'b0;
                    check("reissue_read", 256'({bus.mem_enable_o, bus.mem_write_o}), 256'(2'b10));
                end
                if (bus.mem_enable_o === 1'b1) begin
                    busy     = 1'b1;
                    cur.wr   = bus.mem_write_o;
                    cur.addr = bus.mem_addr_o;
                    cur.data = bus.mem_data_o;
                    left     = int'(resp_lat);
                end
            end
        end
    end

    initial begin : main
        bit          h;
        logic [31:0] r;
        logic [21:0] tags [4];
        logic [31:0] a;
        tags[0] = 22'd0; tags[1] = 22'd1; tags[2] = 22'd2; tags[3] = 22'h3F_FFFF;

        rst_i = 1'b0;
        bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;
        model_reset();
        tick(3);
        check("rst_enable", 256'(bus.mem_enable_o), 256'(1'b0));
        check("rst_write", 256'(bus.mem_write_o), 256'(1'b0));
        check("rst_stall", 256'(bus.cpu_stall_o), 256'(1'b0));
        check_counters();
        rst_i = 1'b1;
        tick(1);

        // Cold miss fetches line 0x40
        access(1'b0, 32'h0000_0040, 32'h0);
        if (txn_q.size() > 0) check("dir_read_addr", 256'(txn_q[0].addr), 256'(32'h40));
        // Store hit, then read it back
        access(1'b1, 32'h0000_0044, 32'h1234_5678);
        access(1'b0, 32'h0000_0044, 32'h0);
        check("dir_store_readback", 256'(last_rdata), 256'(32'h1234_5678));
        // Conflict miss on dirty line: write-back then refill
        access(1'b0, 32'h0000_0440, 32'h0);
        if (txn_q.size() > 1) begin
            check("dir_wb_addr", 256'(txn_q[0].addr), 256'(32'h40));
            check("dir_wb_word", 256'(txn_q[0].data[63:32]), 256'(32'h1234_5678));
            check("dir_refill_addr", 256'(txn_q[1].addr), 256'(32'h440));
        end
        // Clean victim: single read only
        access(1'b0, 32'h0000_0840, 32'h0);
        check("dir_clean_txns", 256'(txn_q.size()), 256'(1));
        check_counters();

        // Reset while waiting for the ALLOC ack
        txn_q.delete();
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h0000_0040;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check("alloc_pending", 256'(bus.mem_enable_o), 256'(1'b1));
        rst_i = 1'b0;
        #1;
        check("rst_mid_enable", 256'(bus.mem_enable_o), 256'(1'b0));
        bus.cpu_req_i = 1'b0;
        tick(2);
        rst_i = 1'b1;
        model_reset();
        check_counters();
        txn_q.delete();
        tick(1);
        access(1'b0, 32'h0000_0040, 32'h0);

        // Request dropped mid-miss: the fill still completes and later hits
        model_step(1'b0, 32'h0000_0060, 32'h0, 1'b0, h, r);
        txn_q.delete();
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h0000_0060;
        tick(2);
        bus.cpu_req_i = 1'b0;
        tick(40);
        check_txns();
        access(1'b0, 32'h0000_0064, 32'h0);

        // Random traffic over a few conflicting tags
        for (int n = 0; n < 300; n++) begin
            resp_lat = $urandom_range(0, 8);
            a = {tags[$urandom_range(0, 3)], 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
            access(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
        end
        check_counters();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
